ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter; the opposite direction to the existing keyboard receive path.
- Sends one command byte to the keyboard, e.g. 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable).
- Drives the open-drain PS2_CLK/PS2_DAT lines through output-enable signals at top level and reports done or error.
- While a transfer is active it asserts rx_inhibit so the receive path ignores clock edges it generates.

---
 rtl/ps2_pkg.sv | 51 +++++
 rtl/ps2_line_sync.sv | 60 ++++++
 rtl/ps2_host_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//
// Shared definitions for the PS/2 host-side blocks (transmit path now, and
// the keyboard receive path where it wants them).
//
// Contents:
//   ps2_tx_state_e   - host transmitter FSM states
//   PS2_CMD_*        - common host-to-keyboard command bytes
//   PS2_RESP_ACK     - byte the keyboard answers with after a command
//   PS2_LAST_EDGE    - index of the last data-carrying falling edge (stop bit)
//   oddParity()      - parity bit that makes the 9-bit {parity,data} word odd
//   maxOf3()         - helper used to size shared timeout counters
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE,
    ERROR
  } ps2_tx_state_e;

  // Frequently used keyboard commands and the keyboard acknowledge byte.
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Falling edges 1..9 carry data bits and parity, edge 10 carries the stop
  // bit, and edge 11 is the one where the device shows its ACK/NACK.
  localparam logic [3:0] PS2_LAST_EDGE = 4'd10;

  // PS/2 frames use odd parity over the eight data bits.
  function automatic logic oddParity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Largest of three integers; used when one counter serves several timeouts.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
//
// Brings the raw, asynchronous PS2_CLK and PS2_DAT line levels into the
// system clock domain through two flip-flops each, and flags the cycle in
// which a synchronized line goes from 1 to 0. Usable unchanged by both the
// host transmit path and the keyboard receive path.
//
// Ports:
//   clk_i       in   system clock
//   rst_ni      in   asynchronous active-low reset
//   ps2_clk_i   in   raw PS2_CLK level
//   ps2_dat_i   in   raw PS2_DAT level
//   clk_sync_o  out  synchronized PS2_CLK level
//   dat_sync_o  out  synchronized PS2_DAT level
//   clk_fall_o  out  1 for one cycle when synchronized PS2_CLK goes 1 -> 0
//   dat_fall_o  out  1 for one cycle when synchronized PS2_DAT goes 1 -> 0
// ---------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic clk_fall_o,
  output logic dat_fall_o
);

  logic [1:0] clkMeta_q;
  logic [1:0] datMeta_q;
  logic       clkPrev_q;
  logic       datPrev_q;

  // Two-stage synchronizers plus one extra stage holding the previous
  // synchronized value for edge detection. Everything resets to 1 because
  // an idle PS/2 bus floats high; resetting to 0 would produce a phantom
  // falling edge right after reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clkMeta_q <= 2'b11;
      datMeta_q <= 2'b11;
      clkPrev_q <= 1'b1;
      datPrev_q <= 1'b1;
    end else begin
      clkMeta_q <= {clkMeta_q[0], ps2_clk_i};
      datMeta_q <= {datMeta_q[0], ps2_dat_i};
      clkPrev_q <= clkMeta_q[1];
      datPrev_q <= datMeta_q[1];
    end
  end

  // The second synchronizer stage is the usable line level; a fall is the
  // previous level high and the current level low.
  assign clk_sync_o = clkMeta_q[1];
  assign dat_sync_o = datMeta_q[1];
  assign clk_fall_o = clkPrev_q & ~clkMeta_q[1];
  assign dat_fall_o = datPrev_q & ~datMeta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (for example
// 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard by pulling the
// open-drain PS2_CLK/PS2_DAT lines low through output enables, then
// reports completion (tx_done) or failure (tx_error).
//
// Sequence: hold CLK low for INHIBIT_CYCLES, release CLK while pulling DAT
// low (request-to-send / start bit), then on each device-generated CLK
// falling edge present the next bit: data LSB first, odd parity, stop (1).
// On the 11th falling edge the device answers by pulling DAT low (ACK).
//
// Ports:
//   CLOCK_50    in   system clock
//   resetn      in   asynchronous active-low reset
//   tx_data     in   byte to send, captured when tx_start is accepted
//   tx_start    in   request pulse, honoured only while tx_ready=1
//   tx_ready    out  1 while idle
//   tx_done     out  one-cycle pulse: ACK received and bus back to idle
//   tx_error    out  one-cycle pulse: start/transfer timeout or NACK
//   rx_inhibit  out  1 while a transfer is in progress
//   ps2_clk_in  in   raw PS2_CLK level
//   ps2_dat_in  in   raw PS2_DAT level
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 5500,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One counter serves the inhibit period and both timeouts, so it is sized
  // for the largest of them.
  localparam int CNT_MAX = maxOf3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES,
                                  XFER_TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter starts at 0 in the cycle after entering a state, so the
  // last cycle of an N-cycle window is reached when it shows N-1.
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q;
  logic [8:0]       shift_q;
  logic [3:0]       edgeCnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clkOe_q;
  logic             datOe_q;
  logic             txDone_q;
  logic             txError_q;

  logic clkSync;
  logic datSync;
  logic clkFall;
  logic datFallUnused;

  // Line synchronizers. The transmitter only needs the CLK falling edge; the
  // DAT edge output exists for the receive path and is left unused here.
  ps2_line_sync uLineSync (
    .clk_i      (CLOCK_50),
    .rst_ni     (resetn),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_dat_i  (ps2_dat_in),
    .clk_sync_o (clkSync),
    .dat_sync_o (datSync),
    .clk_fall_o (clkFall),
    .dat_fall_o (datFallUnused)
  );

  // Transmit FSM. All line enables and status pulses are registered here.
  //
  // The shift register holds {parity, data}. Each device falling edge drives
  // bit 0 onto the line and shifts right with 1s coming in from the top, so
  // after data and parity have gone out the register presents a 1 and the
  // stop bit is produced simply by releasing DAT.
  //
  // edgeCnt_q counts device falling edges: 1 is set by the fall in REQ, 10
  // means the stop bit is on the line, and the fall after that is the
  // ACK/NACK sample.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      edgeCnt_q <= '0;
      cnt_q     <= '0;
      clkOe_q   <= 1'b0;
      datOe_q   <= 1'b0;
      txDone_q  <= 1'b0;
      txError_q <= 1'b0;
    end else begin
      txDone_q  <= 1'b0;
      txError_q <= 1'b0;

      case (state_q)
        IDLE: begin
          clkOe_q   <= 1'b0;
          datOe_q   <= 1'b0;
          cnt_q     <= '0;
          edgeCnt_q <= '0;
          if (tx_start) begin
            shift_q <= {oddParity(tx_data), tx_data};
            clkOe_q <= 1'b1;
            state_q <= INHIBIT;
          end
        end

        // Hold CLK low, then swap to DAT low in a single cycle so the device
        // never sees both lines released between inhibit and request.
        INHIBIT: begin
          if (cnt_q >= INHIBIT_LAST) begin
            clkOe_q   <= 1'b0;
            datOe_q   <= 1'b1;
            cnt_q     <= '0;
            edgeCnt_q <= '0;
            state_q   <= REQ;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        // Start bit is on the line; wait for the device to begin clocking.
        REQ: begin
          if (clkFall) begin
            datOe_q   <= ~shift_q[0];
            shift_q   <= {1'b1, shift_q[8:1]};
            edgeCnt_q <= 4'd1;
            cnt_q     <= '0;
            state_q   <= SHIFT;
          end else if (cnt_q >= START_LAST) begin
            clkOe_q   <= 1'b0;
            datOe_q   <= 1'b0;
            txError_q <= 1'b1;
            state_q   <= ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        // Shift out data, parity and stop; the fall after the stop bit is
        // where the device's ACK (DAT low) or NACK (DAT high) is read.
        SHIFT: begin
          if (clkFall) begin
            if (edgeCnt_q >= PS2_LAST_EDGE) begin
              datOe_q <= 1'b0;
              cnt_q   <= '0;
              if (datSync) begin
                txError_q <= 1'b1;
                state_q   <= ERROR;
              end else begin
                state_q <= WAIT_IDLE;
              end
            end else begin
              datOe_q   <= ~shift_q[0];
              shift_q   <= {1'b1, shift_q[8:1]};
              edgeCnt_q <= edgeCnt_q + 4'd1;
            end
          end else if (cnt_q >= XFER_LAST) begin
            clkOe_q   <= 1'b0;
            datOe_q   <= 1'b0;
            txError_q <= 1'b1;
            state_q   <= ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        // The device still holds DAT (and then CLK) low after the ACK; the
        // transfer is only reported done once both lines are seen high.
        WAIT_IDLE: begin
          clkOe_q <= 1'b0;
          datOe_q <= 1'b0;
          if (clkSync && datSync) begin
            txDone_q <= 1'b1;
            state_q  <= IDLE;
          end else if (cnt_q >= XFER_LAST) begin
            txError_q <= 1'b1;
            state_q   <= ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        // tx_error was raised on entry; spend one cycle here, then idle.
        ERROR: begin
          clkOe_q <= 1'b0;
          datOe_q <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          clkOe_q <= 1'b0;
          datOe_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status and line enables come straight from registers.
  assign tx_ready   = (state_q == IDLE);
  assign rx_inhibit = (state_q != IDLE);
  assign tx_done    = txDone_q;
  assign tx_error   = txError_q;
  assign ps2_clk_oe = clkOe_q;
  assign ps2_dat_oe = datOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Directed bench for ps2_host_tx. A small device model drives PS2_CLK and
// PS2_DAT as open-drain lines (line = device level AND NOT host enable) and
// records the DAT level it sees in the middle of each CLK-low phase.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INHIBIT_CYCLES       = 20;
  localparam int START_TIMEOUT_CYCLES = 100;
  localparam int XFER_TIMEOUT_CYCLES  = 2000;
  localparam int HALF                 = 10;

  logic       CLOCK_50;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;

  logic       devClk;
  logic       devDat;
  logic [9:0] seenLine;
  logic [9:0] seenOe;
  logic       busyReady;
  int         testsRun;
  int         testsFailed;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INHIBIT_CYCLES),
    .START_TIMEOUT_CYCLES (START_TIMEOUT_CYCLES),
    .XFER_TIMEOUT_CYCLES  (XFER_TIMEOUT_CYCLES)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in = devClk & ~ps2_clk_oe;
  assign ps2_dat_in = devDat & ~ps2_dat_oe;

  // 50 MHz-style system clock (period 10 time units).
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance n system cycles, landing 1 unit after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present a byte with a one-cycle tx_start pulse.
  task automatic applyStimulus(input logic [7:0] data);
    tx_data  = data;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
  endtask

  // Wait (bounded) for the host to pull DAT low for the start bit.
  task automatic waitReq(input string tag);
    int n;
    n = 0;
    while (!ps2_dat_oe && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput(tag, ps2_dat_oe, 1);
  endtask

  // Device clocking. Falls 1..10 record the DAT line mid CLK-low. Fall 11
  // drives the ACK/NACK level with CLK low and returns immediately. A frame
  // shorter than 11 falls returns with CLK still low after its last sample.
  // busyFall selects the fall after which a tx_start of 0xFF is attempted.
  task automatic deviceFrame(input int nFalls, input logic ackBit, input int busyFall);
    for (int i = 1; i <= nFalls; i++) begin
      if (i == 11) begin
        devDat = ackBit;
        devClk = 1'b0;
        return;
      end
      devClk = 1'b0;
      tick(HALF);
      seenLine[i-1] = ps2_dat_in;
      seenOe[i-1]   = ps2_dat_oe;
      if (i == nFalls) return;
      devClk = 1'b1;
      if (i == busyFall) begin
        busyReady = tx_ready;
        tx_data   = 8'hFF;
        tx_start  = 1'b1;
        tick(1);
        tx_start  = 1'b0;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
    end
  endtask

  // Request, wait for the start bit, and clock a full frame with ACK/NACK.
  task automatic sendFrame(input logic [7:0] data, input logic ackBit, input string tag);
    applyStimulus(data);
    waitReq(tag);
    tick(HALF);
    deviceFrame(11, ackBit, 0);
  endtask

  // Finish an ACKed frame: release the lines and expect a single tx_done.
  task automatic finishAck(input string tag);
    int   n;
    logic sawError;
    tick(HALF);
    checkOutput({tag, "_no_early_done"}, tx_done, 0);
    devClk = 1'b1;
    devDat = 1'b1;
    n = 0;
    sawError = 1'b0;
    while (!tx_done && n < 50) begin
      tick(1);
      n++;
      if (tx_error) sawError = 1'b1;
    end
    checkOutput({tag, "_done"}, tx_done, 1);
    checkOutput({tag, "_no_error"}, {sawError, tx_error}, 2'b00);
    checkOutput({tag, "_lines_high"}, {ps2_clk_in, ps2_dat_in}, 2'b11);
    tick(1);
    checkOutput({tag, "_done_pulse"}, tx_done, 0);
    checkOutput({tag, "_ready"}, tx_ready, 1);
  endtask

  initial begin
    int n;
    testsRun    = 0;
    testsFailed = 0;
    resetn      = 1'b0;
    tx_data     = 8'h00;
    tx_start    = 1'b0;
    devClk      = 1'b1;
    devDat      = 1'b1;
    seenLine    = '0;
    seenOe      = '0;
    busyReady   = 1'b1;

    // Reset state.
    tick(3);
    checkOutput("reset_ready", tx_ready, 1);
    checkOutput("reset_pulses", {tx_done, tx_error}, 2'b00);
    checkOutput("reset_inhibit", rx_inhibit, 0);
    checkOutput("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    resetn = 1'b1;
    tick(3);
    checkOutput("idle_ready", tx_ready, 1);

    // Basic send of 0xED with inhibit timing.
    applyStimulus(8'hED);
    checkOutput("ed_busy", {tx_ready, rx_inhibit}, 2'b01);
    checkOutput("ed_inhibit_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b10);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      tick(1);
    end
    checkOutput("ed_inhibit_len", n, INHIBIT_CYCLES);
    checkOutput("ed_req_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    tick(HALF);
    deviceFrame(11, 1'b0, 0);
    checkOutput("ed_bits", seenLine, 10'h3ED);
    checkOutput("ed_inhibit_during", rx_inhibit, 1);
    finishAck("ed");

    // Parity of 0x00 (bit 1, released) and 0x01 (bit 0, driven).
    sendFrame(8'h00, 1'b0, "p00_req");
    checkOutput("p00_bits", seenLine, 10'h300);
    checkOutput("p00_par_oe", seenOe[8], 0);
    finishAck("p00");
    sendFrame(8'h01, 1'b0, "p01_req");
    checkOutput("p01_bits", seenLine, 10'h201);
    checkOutput("p01_par_oe", seenOe[8], 1);
    finishAck("p01");

    // NACK on 0xF4.
    sendFrame(8'hF4, 1'b1, "nack_req");
    checkOutput("nack_bits", seenLine, 10'h2F4);
    n = 0;
    while (!tx_error && !tx_done && n < 50) begin
      tick(1);
      n++;
    end
    checkOutput("nack_error", tx_error, 1);
    checkOutput("nack_no_done", tx_done, 0);
    checkOutput("nack_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    tick(1);
    checkOutput("nack_ready", {tx_ready, tx_error}, 2'b10);
    devClk = 1'b1;
    devDat = 1'b1;
    tick(5);

    // Start timeout: the device never clocks.
    applyStimulus(8'hF4);
    waitReq("tmo_req");
    n = 0;
    while (!tx_error && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput("tmo_cycles", n, START_TIMEOUT_CYCLES);
    checkOutput("tmo_oe", {ps2_clk_oe, ps2_dat_oe, tx_done}, 3'b000);
    tick(1);
    checkOutput("tmo_ready", {tx_ready, tx_error}, 2'b10);

    // Busy start ignored, then asynchronous reset mid-SHIFT.
    applyStimulus(8'h3C);
    waitReq("busy_req");
    tick(HALF);
    deviceFrame(8, 1'b0, 4);
    checkOutput("busy_not_ready", busyReady, 0);
    checkOutput("busy_bits", seenLine[7:0], 8'h3C);
    checkOutput("busy_pre_reset_oe", ps2_dat_oe, 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    checkOutput("rst_ready", tx_ready, 1);
    checkOutput("rst_no_pulse", {tx_done, tx_error}, 2'b00);
    devClk = 1'b1;
    devDat = 1'b1;
    tick(2);
    resetn = 1'b1;
    tick(5);
    checkOutput("rst_idle", {tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
